// File: rtl/pipeline_control_if.sv
// Shared PC-select type and the datapath <-> pipeline_control signal bundle.
// master = datapath side, slave = pipeline_control.
package pipeline_control_pkg;
    typedef enum logic [1:0] {
        SEL_PC_NONE   = 2'd0,
        SEL_PC_BRANCH = 2'd1,
        SEL_PC_JAL    = 2'd2,
        SEL_PC_JALR   = 2'd3
    } sel_pc_t;
endpackage

interface pipeline_control_if #(
    parameter int NUM_STAGES = 5,
    parameter int XLEN       = 32
);
    import pipeline_control_pkg::*;

    logic                  imem_ready_i;
    logic                  mem_req_i;
    logic                  mem_done_i;
    sel_pc_t               pc_sel_i;
    logic                  br_taken_i;
    logic [XLEN-1:0]       next_pc_i;
    logic                  halt_i;
    logic [NUM_STAGES-1:0] stage_en_o;
    logic [NUM_STAGES-1:0] stage_flush_o;
    sel_pc_t               pc_sel_o;
    logic [XLEN-1:0]       next_pc_o;
    logic                  redirect_o;
    logic [1:0]            state_o;
    logic [31:0]           stall_cycles_o;

    modport master (
        output imem_ready_i, mem_req_i, mem_done_i, pc_sel_i, br_taken_i, next_pc_i, halt_i,
        input  stage_en_o, stage_flush_o, pc_sel_o, next_pc_o, redirect_o, state_o, stall_cycles_o
    );

    modport slave (
        input  imem_ready_i, mem_req_i, mem_done_i, pc_sel_i, br_taken_i, next_pc_i, halt_i,
        output stage_en_o, stage_flush_o, pc_sel_o, next_pc_o, redirect_o, state_o, stall_cycles_o
    );
endinterface

// File: rtl/pipeline_control.sv
// Pipeline sequencer: reset-PC / warm-up sequencing, stall and redirect arbitration into
// per-stage enable/flush vectors, and a saturating stalled-cycle counter.
//
// state  | meaning
// IDLE   | first cycle after reset, PC loads RESET_PC, all pipeline regs bubble
// WARMUP | PC held at RESET_PC for WARMUP_CYCLES cycles while bubbles drain
// RUN    | normal operation, stall/redirect arbitration active
// HALT   | everything frozen until reset
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int              NUM_STAGES    = 5,
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_PC      = '0,
    parameter int              WARMUP_CYCLES = 1,
    parameter int              FLUSH_STAGES  = 2,
    parameter logic [31:0]     STALL_INIT    = 32'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    pipeline_control_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam int                    WB         = NUM_STAGES - 1;
    localparam logic [NUM_STAGES-1:0] ALL_ONES   = '1;
    localparam logic [NUM_STAGES-1:0] ONE        = 1;
    localparam logic [NUM_STAGES-1:0] IDLE_FLUSH = ALL_ONES & ~ONE;
    // bits 1..FLUSH_STAGES
    localparam logic [NUM_STAGES-1:0] REDIR_FLUSH =
        (ALL_ONES >> (NUM_STAGES - 1 - FLUSH_STAGES)) & ~ONE;
    localparam logic [7:0]            WARM_LAST  = 8'(WARMUP_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_warm_cnt;
    logic [31:0] r_stall_cnt;

    logic                  w_mem_stall;
    logic                  w_fetch_stall;
    logic                  w_redirect_req;
    logic                  w_stall_evt;
    logic [NUM_STAGES-1:0] w_en;
    logic [NUM_STAGES-1:0] w_flush;
    sel_pc_t               w_pc_sel;
    logic [XLEN-1:0]       w_next_pc;
    logic                  w_redirect;

    assign w_mem_stall    = bus.mem_req_i & ~bus.mem_done_i;
    assign w_fetch_stall  = ~bus.imem_ready_i;
    assign w_redirect_req = (bus.pc_sel_i == SEL_PC_JAL) || (bus.pc_sel_i == SEL_PC_JALR) ||
                            ((bus.pc_sel_i == SEL_PC_BRANCH) && bus.br_taken_i);
    assign w_stall_evt    = w_mem_stall | (w_fetch_stall & ~w_redirect_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_warm_cnt  <= '0;
            r_stall_cnt <= STALL_INIT;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;
                ST_WARMUP: begin
                    r_warm_cnt <= r_warm_cnt + 8'd1;
                    if (r_warm_cnt == WARM_LAST) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF))
                        r_stall_cnt <= r_stall_cnt + 32'd1;
                    if (bus.halt_i && !w_mem_stall) r_state <= ST_HALT;
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

    always_comb begin
        w_en       = ALL_ONES;
        w_flush    = '0;
        w_pc_sel   = SEL_PC_NONE;
        w_next_pc  = RESET_PC;
        w_redirect = 1'b0;
        case (r_state)
            ST_IDLE: w_flush = IDLE_FLUSH;
            ST_WARMUP: begin
                w_flush = IDLE_FLUSH;
                w_en[0] = 1'b0;
            end
            ST_RUN: begin
                w_pc_sel  = bus.pc_sel_i;
                w_next_pc = bus.next_pc_i;
                if (w_mem_stall) begin
                    // EX stays frozen, so a pending redirect is re-presented next cycle
                    w_en        = '0;
                    w_en[WB]    = 1'b1;
                    w_flush[WB] = 1'b1;
                end else if (w_redirect_req) begin
                    w_flush    = REDIR_FLUSH;
                    w_redirect = 1'b1;
                end else if (w_fetch_stall) begin
                    w_en[0]    = 1'b0;
                    w_flush[1] = 1'b1;
                end
            end
            default: begin
                w_en    = '0;
                w_flush = '0;
            end
        endcase
    end

    assign bus.stage_en_o     = w_en;
    assign bus.stage_flush_o  = w_flush;
    assign bus.pc_sel_o       = w_pc_sel;
    assign bus.next_pc_o      = w_next_pc;
    assign bus.redirect_o     = w_redirect;
    assign bus.state_o        = r_state;
    assign bus.stall_cycles_o = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: default 5-stage instance plus a 4-stage,
// zero-warm-up instance whose counter starts near saturation.
module tb_pipeline_control;
    import pipeline_control_pkg::*;

    logic clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipeline_control_if #(.NUM_STAGES(5), .XLEN(32)) bus_a ();
    pipeline_control_if #(.NUM_STAGES(4), .XLEN(32)) bus_b ();

    pipeline_control #(
        .NUM_STAGES(5), .XLEN(32), .RESET_PC(32'h0), .WARMUP_CYCLES(1),
        .FLUSH_STAGES(2), .STALL_INIT(32'h0)
    ) dut_a (.clk(clk), .rst_n(rst_n_a), .bus(bus_a));

    pipeline_control #(
        .NUM_STAGES(4), .XLEN(32), .RESET_PC(32'h0), .WARMUP_CYCLES(0),
        .FLUSH_STAGES(1), .STALL_INIT(32'hFFFF_FFFE)
    ) dut_b (.clk(clk), .rst_n(rst_n_b), .bus(bus_b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic imem, input logic mreq, input logic mdone,
                         input sel_pc_t sel, input logic br, input logic [31:0] npc,
                         input logic halt);
        bus_a.imem_ready_i = imem;
        bus_a.mem_req_i    = mreq;
        bus_a.mem_done_i   = mdone;
        bus_a.pc_sel_i     = sel;
        bus_a.br_taken_i   = br;
        bus_a.next_pc_i    = npc;
        bus_a.halt_i       = halt;
        #1;
    endtask

    task automatic set_b(input logic imem, input logic mreq, input logic mdone,
                         input sel_pc_t sel, input logic br, input logic [31:0] npc);
        bus_b.imem_ready_i = imem;
        bus_b.mem_req_i    = mreq;
        bus_b.mem_done_i   = mdone;
        bus_b.pc_sel_i     = sel;
        bus_b.br_taken_i   = br;
        bus_b.next_pc_i    = npc;
        bus_b.halt_i       = 1'b0;
        #1;
    endtask

    initial begin
        set_a(1'b1, 1'b0, 1'b0, SEL_PC_NONE, 1'b0, 32'h40, 1'b0);
        set_b(1'b1, 1'b0, 1'b0, SEL_PC_NONE, 1'b0, 32'h0);

        // reset held
        chk("rst_state", 64'(bus_a.state_o), 64'd0);
        chk("rst_en", 64'(bus_a.stage_en_o), 64'b11111);
        chk("rst_flush", 64'(bus_a.stage_flush_o), 64'b11110);
        chk("rst_npc", 64'(bus_a.next_pc_o), 64'h0);
        chk("rst_redir", 64'(bus_a.redirect_o), 64'd0);
        chk("rst_cnt", 64'(bus_a.stall_cycles_o), 64'd0);

        tick(); tick();
        rst_n_a = 1'b1;
        #1;
        chk("c0_state", 64'(bus_a.state_o), 64'd0);
        chk("c0_en", 64'(bus_a.stage_en_o), 64'b11111);
        chk("c0_npc", 64'(bus_a.next_pc_o), 64'h0);
        chk("c0_sel", 64'(bus_a.pc_sel_o), 64'(SEL_PC_NONE));

        tick();
        chk("c1_state", 64'(bus_a.state_o), 64'd1);
        chk("c1_en", 64'(bus_a.stage_en_o), 64'b11110);
        chk("c1_flush", 64'(bus_a.stage_flush_o), 64'b11110);
        chk("c1_npc", 64'(bus_a.next_pc_o), 64'h0);

        tick();
        chk("c2_state", 64'(bus_a.state_o), 64'd2);
        chk("c2_en", 64'(bus_a.stage_en_o), 64'b11111);
        chk("c2_flush", 64'(bus_a.stage_flush_o), 64'b00000);
        chk("c2_npc", 64'(bus_a.next_pc_o), 64'h40);

        // taken branch wins over fetch stall
        set_a(1'b0, 1'b0, 1'b0, SEL_PC_BRANCH, 1'b1, 32'h100, 1'b0);
        chk("br_redir", 64'(bus_a.redirect_o), 64'd1);
        chk("br_en", 64'(bus_a.stage_en_o), 64'b11111);
        chk("br_flush", 64'(bus_a.stage_flush_o), 64'b00110);
        chk("br_npc", 64'(bus_a.next_pc_o), 64'h100);
        chk("br_sel", 64'(bus_a.pc_sel_o), 64'(SEL_PC_BRANCH));
        tick();
        chk("br_cnt", 64'(bus_a.stall_cycles_o), 64'd0);

        // not-taken branch: plain run
        set_a(1'b1, 1'b0, 1'b0, SEL_PC_BRANCH, 1'b0, 32'h180, 1'b0);
        chk("nt_redir", 64'(bus_a.redirect_o), 64'd0);
        chk("nt_flush", 64'(bus_a.stage_flush_o), 64'b00000);
        chk("nt_en", 64'(bus_a.stage_en_o), 64'b11111);
        tick();

        // memory stall holds a jump for 3 cycles
        set_a(1'b1, 1'b1, 1'b0, SEL_PC_JAL, 1'b0, 32'h200, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("ms_en", 64'(bus_a.stage_en_o), 64'b10000);
            chk("ms_flush", 64'(bus_a.stage_flush_o), 64'b10000);
            chk("ms_redir", 64'(bus_a.redirect_o), 64'd0);
            tick();
        end
        set_a(1'b1, 1'b1, 1'b1, SEL_PC_JAL, 1'b0, 32'h200, 1'b0);
        chk("md_redir", 64'(bus_a.redirect_o), 64'd1);
        chk("md_en", 64'(bus_a.stage_en_o), 64'b11111);
        chk("md_flush", 64'(bus_a.stage_flush_o), 64'b00110);
        chk("md_npc", 64'(bus_a.next_pc_o), 64'h200);
        chk("ms_cnt", 64'(bus_a.stall_cycles_o), 64'd3);
        tick();
        chk("md_cnt", 64'(bus_a.stall_cycles_o), 64'd3);

        // fetch stall alone, 2 cycles
        set_a(1'b0, 1'b0, 1'b0, SEL_PC_NONE, 1'b0, 32'h204, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk("fs_en", 64'(bus_a.stage_en_o), 64'b11110);
            chk("fs_flush", 64'(bus_a.stage_flush_o), 64'b00010);
            tick();
        end
        chk("fs_cnt", 64'(bus_a.stall_cycles_o), 64'd5);

        // halt blocked by mem stall, then taken
        set_a(1'b1, 1'b1, 1'b0, SEL_PC_NONE, 1'b0, 32'h208, 1'b1);
        tick();
        chk("hms_state", 64'(bus_a.state_o), 64'd2);
        chk("hms_cnt", 64'(bus_a.stall_cycles_o), 64'd6);
        set_a(1'b1, 1'b0, 1'b0, SEL_PC_NONE, 1'b0, 32'h208, 1'b1);
        tick();
        chk("h_state", 64'(bus_a.state_o), 64'd3);
        chk("h_en", 64'(bus_a.stage_en_o), 64'd0);
        chk("h_flush", 64'(bus_a.stage_flush_o), 64'd0);
        set_a(1'b0, 1'b1, 1'b0, SEL_PC_JAL, 1'b0, 32'h300, 1'b0);
        tick(); tick();
        chk("hs_state", 64'(bus_a.state_o), 64'd3);
        chk("hs_en", 64'(bus_a.stage_en_o), 64'd0);
        chk("hs_redir", 64'(bus_a.redirect_o), 64'd0);
        chk("hs_sel", 64'(bus_a.pc_sel_o), 64'(SEL_PC_NONE));
        chk("hs_cnt", 64'(bus_a.stall_cycles_o), 64'd6);

        // async reset mid-HALT, no clock edge in between
        rst_n_a = 1'b0;
        #1;
        chk("ar_state", 64'(bus_a.state_o), 64'd0);
        chk("ar_en", 64'(bus_a.stage_en_o), 64'b11111);
        chk("ar_flush", 64'(bus_a.stage_flush_o), 64'b11110);
        chk("ar_cnt", 64'(bus_a.stall_cycles_o), 64'd0);

        // 4-stage instance, no warm-up, counter starting at 0xFFFFFFFE
        tick();
        rst_n_b = 1'b1;
        #1;
        chk("b0_state", 64'(bus_b.state_o), 64'd0);
        chk("b0_flush", 64'(bus_b.stage_flush_o), 64'b1110);
        tick();
        chk("b1_state", 64'(bus_b.state_o), 64'd2);
        chk("b1_cnt", 64'(bus_b.stall_cycles_o), 64'hFFFF_FFFE);
        set_b(1'b1, 1'b1, 1'b0, SEL_PC_NONE, 1'b0, 32'h10);
        chk("bms_en", 64'(bus_b.stage_en_o), 64'b1000);
        chk("bms_flush", 64'(bus_b.stage_flush_o), 64'b1000);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bsat_cnt", 64'(bus_b.stall_cycles_o), 64'hFFFF_FFFF);
        end
        set_b(1'b1, 1'b0, 1'b0, SEL_PC_JALR, 1'b0, 32'h80);
        chk("brd_redir", 64'(bus_b.redirect_o), 64'd1);
        chk("brd_en", 64'(bus_b.stage_en_o), 64'b1111);
        chk("brd_flush", 64'(bus_b.stage_flush_o), 64'b0010);
        chk("brd_npc", 64'(bus_b.next_pc_o), 64'h80);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
